inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time writer for the instruction RAM; the pipeline's fetch stage is the read end of that RAM.
Accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive instruction RAM addresses starting at 0.
Validates an XOR checksum at the end of the frame.
Holds the processor core in reset through core_hold until a load completes without error.

Parameters:
PC_WIDTH, 8, instruction RAM address width; also the width of ram_addr.
DATA_WIDTH, 16, instruction word width; fixed at two bytes.
BYTE_WIDTH, 8, width of stream symbols and of the checksum.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
rx_data  input  BYTE_WIDTH  stream byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at a clk edge.
ram_wr_en  output  1  instruction RAM write strobe; one cycle per word.
ram_addr  output  PC_WIDTH  instruction RAM write address.
ram_wr_data  output  DATA_WIDTH  instruction word to write.
core_hold  output  1  1 = keep the core in reset; ORed into the core reset by the integrator.
load_done  output  1  level; last load succeeded.
load_err  output  1  level; last load failed its checksum.

Behaviour:
- Reset (reset=0, asynchronous) puts the FSM in IDLE and drives the outputs as follows:
  - rx_ready=0, ram_wr_en=0, load_done=0, load_err=0.
  - ram_addr=0, ram_wr_data=0.
  - core_hold=1.
  - Word counter and checksum accumulator are cleared to 0.
- Reset asserted mid-load aborts the load immediately. RAM contents already written are left as-is.
- Frame format: COUNT byte, then 2*N data bytes (high byte first per word), then CHK byte.
  - N = COUNT, except COUNT=0 means N=256.
  - Addresses wrap modulo 2^PC_WIDTH.
- FSM states: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
- rx_ready=1 only in COUNT, HI, LO and CHECK. rx_ready is a registered state decode and does not depend on rx_valid.
- State transitions:
  - IDLE/DONE/ERROR + start -> COUNT. Entering COUNT sets core_hold=1, clears load_done and load_err, sets ram_addr=0, and clears the checksum.
  - COUNT + transfer -> HI. Latch N.
  - HI + transfer -> LO. Latch the high byte; checksum ^= byte.
  - LO + transfer -> WRITE. ram_wr_data={hi,byte}; checksum ^= byte.
  - WRITE (exactly one cycle): ram_wr_en=1 with the current ram_addr and ram_wr_data.
    - On exit, ram_addr increments and the word counter increments.
    - Next state is CHECK if the word counter reaches N, otherwise HI.
  - CHECK + transfer:
    - byte == checksum -> DONE, with load_done=1 and core_hold=0.
    - byte != checksum -> ERROR, with load_err=1 and core_hold=1.
- The COUNT byte is not included in the checksum.
- Latency: a word is written 1 cycle after its low byte is accepted. Best-case throughput is 1 word per 3 cycles.
- rx_valid low stalls the FSM in its current state with no side effects.
- start asserted in COUNT, HI, LO, WRITE or CHECK is ignored.
- start and a transfer in the same cycle while in DONE: start wins, and the byte is not consumed (rx_ready=0 in DONE).
- ram_wr_en is never asserted outside WRITE.
- ram_addr and ram_wr_data hold their values outside WRITE.
- load_done and load_err are never both 1.

Test Plan:
- Reset then release with no start -> core_hold=1, rx_ready=0, ram_wr_en never asserted over 100 cycles.
- start; stream 02,12,34,AB,CD,checksum 12^34^AB^CD=40, rx_valid held 1 -> writes addr0=1234 then addr1=ABCD, one ram_wr_en cycle each; load_done=1 and core_hold=0 the cycle after CHK is accepted.
- Same frame with CHK=41 -> both words written, load_err=1, load_done=0, core_hold stays 1; a new start clears load_err and a correct frame then reaches DONE.
- COUNT=00, 512 data bytes with value (i mod 256) -> 256 writes, addresses 00..FF, correct CHK -> load_done=1, ram_addr wraps to 00.
- Random rx_valid gaps plus a start pulse mid-frame -> identical RAM writes to the gap-free run; the mid-frame start is ignored.
- Reset pulsed low while in LO -> all outputs return to reset values within the same cycle (async); a fresh frame loads correctly from addr 0.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream handshake into the instruction loader.
//   rx_data  : stream byte
//   rx_valid : rx_data is valid (driven by the source)
//   rx_ready : loader accepts a byte (driven by the loader)
// A byte transfers on a rising clk edge when rx_valid && rx_ready.
// master = stream source, slave = inst_loader.
interface inst_loader_if #(
    parameter int BYTE_WIDTH = 8
) ();
    logic [BYTE_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction RAM writer.
// Receives a frame  COUNT, {HI, LO} x N, CHK  over the rx handshake,
// writes N 16-bit words to consecutive RAM addresses from 0 and checks
// an XOR checksum over the data bytes.  The core is held in reset
// (core_hold=1) until a load finishes with a good checksum.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   start       : one-cycle load request (honoured in IDLE/DONE/ERROR)
//   rx          : byte stream (slave side of inst_loader_if)
//   ram_wr_en   : RAM write strobe, one cycle per word
//   ram_addr    : RAM write address
//   ram_wr_data : RAM write word
//   core_hold   : 1 = keep core in reset
//   load_done   : last load succeeded
//   load_err    : last load failed its checksum
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | after reset, waiting for start
// COUNT | waiting for the word-count byte (0 means 256)
// HI    | waiting for the high byte of a word
// LO    | waiting for the low byte of a word
// WRITE | one-cycle RAM write strobe
// CHECK | waiting for the checksum byte
// DONE  | load good, core released
// ERROR | checksum mismatch, core held
module inst_loader #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    inst_loader_if.slave          rx,
    output logic                  ram_wr_en,
    output logic [PC_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    // One extra bit so the count can hold 256 (COUNT byte of 0).
    localparam int CNT_W = BYTE_WIDTH + 1;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  ready_q;
    logic                  ready_nxt;
    logic                  xfer;
    logic [CNT_W-1:0]      n_words;
    logic [CNT_W-1:0]      word_cnt;
    logic [CNT_W-1:0]      word_cnt_inc;
    logic [BYTE_WIDTH-1:0] hi_byte;
    logic [BYTE_WIDTH-1:0] checksum;

    assign rx.rx_ready   = ready_q;
    assign xfer          = rx.rx_valid && ready_q;
    assign word_cnt_inc  = word_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_COUNT;
            S_COUNT: if (xfer) state_nxt = S_HI;
            S_HI:    if (xfer) state_nxt = S_LO;
            S_LO:    if (xfer) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (word_cnt_inc == n_words) ? S_CHECK : S_HI;
            S_CHECK: if (xfer) state_nxt = (rx.rx_data == checksum) ? S_DONE : S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // rx_ready and ram_wr_en are registered decodes of the next state, so
    // they are glitch-free and line up exactly with the state they belong to.
    assign ready_nxt = (state_nxt == S_COUNT) || (state_nxt == S_HI) ||
                       (state_nxt == S_LO)    || (state_nxt == S_CHECK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            core_hold   <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            n_words     <= '0;
            word_cnt    <= '0;
            hi_byte     <= '0;
            checksum    <= '0;
        end else begin
            state     <= state_nxt;
            ready_q   <= ready_nxt;
            ram_wr_en <= (state_nxt == S_WRITE);
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        core_hold <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        ram_addr  <= '0;
                        checksum  <= '0;
                        word_cnt  <= '0;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        n_words <= (rx.rx_data == '0) ? {1'b1, {BYTE_WIDTH{1'b0}}}
                                                      : {1'b0, rx.rx_data};
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_byte  <= rx.rx_data;
                        checksum <= checksum ^ rx.rx_data;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        ram_wr_data <= {hi_byte, rx.rx_data};
                        checksum    <= checksum ^ rx.rx_data;
                    end
                end
                S_WRITE: begin
                    ram_addr <= ram_addr + PC_WIDTH'(1);
                    word_cnt <= word_cnt_inc;
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (rx.rx_data == checksum) begin
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            load_err  <= 1'b1;
                            core_hold <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ram_wr_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wr_data;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    inst_loader_if #(.BYTE_WIDTH(8)) rx_if ();

    inst_loader #(.PC_WIDTH(8), .DATA_WIDTH(16), .BYTE_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .rx          (rx_if),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .core_hold   (core_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [23:0] sb[$];
    logic [15:0] words[$];
    logic [23:0] mon_e;
    logic        prev_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_wr_en === 1'b1) begin
            n_writes++;
            check("wr_single_cycle", 32'(prev_wr), 0);
            check("write_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(mon_e[23:16]));
                check("wr_data", 32'(ram_wr_data), 32'(mon_e[15:0]));
            end
        end
        if (load_done === 1'b1 || load_err === 1'b1)
            check("done_err_exclusive", 32'(load_done & load_err), 0);
        prev_wr = ram_wr_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one byte and returns at posedge+1 after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int k;
        ok = 1'b0;
        if (gaps) begin
            k = $urandom_range(0, 3);
            rx_if.rx_valid = 1'b0;
            repeat (k) begin @(posedge clk); #1; end
        end
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_if.rx_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        rx_if.rx_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 1);
    endtask

    // Sends the frame held in words[]; chk_flip corrupts the checksum byte.
    task automatic send_frame(input bit gaps, input bit mid_start, input logic [7:0] chk_flip);
        logic [7:0] c;
        logic [7:0] a;
        c = 8'h00;
        a = 8'h00;
        send_byte(8'(words.size()), gaps);
        foreach (words[i]) begin
            send_byte(words[i][15:8], gaps);
            c = c ^ words[i][15:8];
            sb.push_back({a, words[i]});
            send_byte(words[i][7:0], gaps);
            c = c ^ words[i][7:0];
            a = a + 8'd1;
            if (mid_start && i == 0) begin
                pulse_start();
                pulse_start();
            end
        end
        send_byte(c ^ chk_flip, gaps);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_if.rx_ready), 0);
        check({tag, "_wr_en"},    32'(ram_wr_en), 0);
        check({tag, "_addr"},     32'(ram_addr), 0);
        check({tag, "_data"},     32'(ram_wr_data), 0);
        check({tag, "_hold"},     32'(core_hold), 1);
        check({tag, "_done"},     32'(load_done), 0);
        check({tag, "_err"},      32'(load_err), 0);
    endtask

    int w0;

    initial begin
        rst_n          = 1'b1;
        start          = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle with no start: nothing moves for 100 cycles.
        repeat (100) begin @(posedge clk); #1; end
        check("idle_hold", 32'(core_hold), 1);
        check("idle_rx_ready", 32'(rx_if.rx_ready), 0);
        check("idle_writes", 32'(n_writes), 0);

        // Good two-word frame, gap-free.
        words = '{16'h1234, 16'hABCD};
        pulse_start();
        send_frame(1'b0, 1'b0, 8'h00);
        check("good_done", 32'(load_done), 1);
        check("good_hold", 32'(core_hold), 0);
        check("good_err", 32'(load_err), 0);
        check("good_rx_ready", 32'(rx_if.rx_ready), 0);
        check("good_addr_end", 32'(ram_addr), 2);
        check("good_sb_empty", 32'(sb.size()), 0);
        check("good_writes", 32'(n_writes), 2);

        // Start together with a valid byte while in DONE: start wins, the
        // byte stays on the bus and becomes the COUNT byte next cycle.
        rx_if.rx_data  = 8'h01;
        rx_if.rx_valid = 1'b1;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_ready", 32'(rx_if.rx_ready), 1);
        check("done_start_done", 32'(load_done), 0);
        check("done_start_hold", 32'(core_hold), 1);
        words = '{16'h5A5A};
        send_frame(1'b0, 1'b0, 8'h00);
        check("single_done", 32'(load_done), 1);
        check("single_sb_empty", 32'(sb.size()), 0);

        // Bad checksum (0x40 expected, 0x41 sent).
        words = '{16'h1234, 16'hABCD};
        w0 = n_writes;
        pulse_start();
        send_frame(1'b0, 1'b0, 8'h01);
        check("bad_err", 32'(load_err), 1);
        check("bad_done", 32'(load_done), 0);
        check("bad_hold", 32'(core_hold), 1);
        check("bad_writes", 32'(n_writes - w0), 2);
        pulse_start();
        check("restart_err_clear", 32'(load_err), 0);
        check("restart_hold", 32'(core_hold), 1);
        check("restart_addr", 32'(ram_addr), 0);
        check("restart_ready", 32'(rx_if.rx_ready), 1);
        send_frame(1'b0, 1'b0, 8'h00);
        check("recover_done", 32'(load_done), 1);
        check("recover_err", 32'(load_err), 0);

        // COUNT=0 -> 256 words, bytes (i mod 256), checksum 0, address wraps.
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back({8'(2 * i), 8'(2 * i + 1)});
        w0 = n_writes;
        pulse_start();
        send_frame(1'b0, 1'b0, 8'h00);
        check("full_writes", 32'(n_writes - w0), 256);
        check("full_done", 32'(load_done), 1);
        check("full_addr_wrap", 32'(ram_addr), 0);
        check("full_sb_empty", 32'(sb.size()), 0);

        // Random rx_valid gaps plus ignored start pulses mid-frame.
        words = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, 16'h8796};
        w0 = n_writes;
        pulse_start();
        send_frame(1'b1, 1'b1, 8'h00);
        check("gap_writes", 32'(n_writes - w0), 5);
        check("gap_done", 32'(load_done), 1);
        check("gap_addr_end", 32'(ram_addr), 5);
        check("gap_sb_empty", 32'(sb.size()), 0);

        // Asynchronous reset while in LO.
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        check("lo_ready_before_reset", 32'(rx_if.rx_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");
        words = '{16'hBEEF, 16'h0102, 16'h7F80};
        w0 = n_writes;
        pulse_start();
        send_frame(1'b0, 1'b0, 8'h00);
        check("fresh_writes", 32'(n_writes - w0), 3);
        check("fresh_done", 32'(load_done), 1);
        check("fresh_hold", 32'(core_hold), 0);
        check("fresh_sb_empty", 32'(sb.size()), 0);

        repeat (3) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
